neopixel_frame_sched: RTL and testbench
=======================================

Name: neopixel_frame_sched

Overview:
- Frame controller that sits between the UART byte receiver and the writepixel serialiser.
- Holds a NUM_PIXELS x 24-bit pixel buffer that the host fills as an R,G,B byte stream.
- Periodically, or on demand, walks the buffer and feeds one pixel at a time to writepixel over its valid/busy handshake.
- Inserts the strip latch gap after every frame and reports frame status.

Parameters:
- NUM_PIXELS, 10, pixels per frame (>=1)
- IDX_W, 4, pixel index width; 2^IDX_W >= NUM_PIXELS
- CNT_W, 24, width of refresh/latch timer
- REFRESH_CYCLES, 1200000, CLK cycles from frame start to next automatic frame start (100 ms at 12 MHz)
- LATCH_CYCLES, 1000, CLK cycles data line held idle after last pixel (>80 us at 12 MHz)

Ports:
- CLK  in  1  system clock; sole clock
- RST  in  1  synchronous, active-high reset
- i_wr_en  in  1  host byte strobe (from rxuart rx_valid)
- i_wr_data  in  8  host byte
- i_wr_sof  in  1  qualified by i_wr_en: this byte is R of pixel 0
- i_refresh_now  in  1  request an immediate frame
- i_busy  in  1  writepixel busy
- o_valid  out  1  one-cycle pixel strobe to writepixel
- o_r, o_g, o_b  out  8 each  pixel colour to writepixel, stable from o_valid until i_busy falls
- o_frame_busy  out  1  high from frame start to end of latch gap
- o_frame_done  out  1  one-cycle pulse at end of latch gap
- o_pixel_idx  out  IDX_W  index of pixel currently being sent

Behaviour:
- Reset: all outputs 0; FSM->IDLE; write pointer->pixel 0, colour R; timer 0; pending flag cleared. Buffer contents are not cleared by reset; power-up contents are all zero.
- Host write path, independent of the FSM:
  - Each i_wr_en stores the byte into the current pixel/colour and advances R->G->B->next pixel.
  - After the B byte of pixel NUM_PIXELS-1 the pointer wraps to pixel 0, colour R.
  - i_wr_sof with i_wr_en forces the byte into pixel 0 R; the next byte goes to pixel 0 G.
  - Writes during a frame are allowed. A pixel already loaded for sending is unaffected; pixels not yet loaded take the new value.
- Timer: counts every cycle in IDLE; cleared at each frame start.
- FSM states:
  - IDLE: start a frame when timer == REFRESH_CYCLES-1, or i_refresh_now, or pending flag, AND i_busy==0. If i_busy==1 (e.g. after reset mid-pixel), wait in IDLE.
  - LOAD: idx<=current pixel; buffer read into o_r/o_g/o_b (1 cycle).
  - SEND: o_valid=1 for exactly one cycle -> WAIT_ACK.
  - WAIT_ACK: wait for i_busy==1 -> WAIT_DONE.
  - WAIT_DONE: wait for i_busy==0. If idx==NUM_PIXELS-1 -> LATCH with timer cleared; else idx+1 -> LOAD.
  - LATCH: hold LATCH_CYCLES cycles. In the last cycle pulse o_frame_done, drop o_frame_busy, go to IDLE with timer cleared.
- Pixel timing: valid-to-valid spacing = writepixel busy time + 3 cycles.
- o_frame_busy goes high in the cycle after the start condition.
- i_refresh_now while o_frame_busy=1 sets the pending flag; a single flag absorbs any number of requests. The next frame starts in the first IDLE cycle. The pending flag is cleared at frame start.
- i_refresh_now and timer expiry in the same cycle start one frame.
- RST mid-frame: o_valid drops at once. A pixel already in flight in writepixel completes on its own; the IDLE busy check prevents overlap.

Optional Feature:
- Macro: NEOPIXEL_SCHED_BRIGHTNESS_EN.
- When defined:
  - Extra port i_brightness in 8 is sampled at frame start and held for the whole frame.
  - Each colour is sent as (c * (brightness+1)) >> 8 (16-bit product, upper byte).
  - 255 is a passthrough; 0 gives c>>8 = 0. LOAD becomes 2 cycles (read, multiply).
- When undefined: no port; colours are sent unmodified; LOAD is 1 cycle.

Test Plan:
- Reset then idle with REFRESH_CYCLES=200, LATCH_CYCLES=20, NUM_PIXELS=3, and a writepixel model busy 10 cycles. First o_valid 202 cycles after RST release. 3 valid pulses, 13 cycles apart. o_frame_done 20 cycles after the last busy fall.
- Write bytes with sof: 0x11,0x22,0x33,0x44,0x55,0x66 then i_refresh_now. Pixel0 = r11 g22 b33, pixel1 = r44 g55 b66, pixel2 = 0.
- i_refresh_now three times during a frame. Exactly one extra frame starts the cycle after o_frame_done, then auto refresh resumes.
- Host writes pixel2 = 0xAA,0xBB,0xCC while pixel0 is sending. Pixel2 goes out as AA/BB/CC. Rewriting pixel0 while it is in WAIT_DONE does not change o_r/o_g/o_b.
- Assert RST in WAIT_DONE of pixel1 with busy still high for 6 cycles. o_valid stays 0, and no frame starts until busy falls and the timer expires.
- Brightness build: i_brightness=127, pixel r=0xFF g=0x80 b=0x01. Sent values 0x7F, 0x40, 0x00.

Source files
------------

// File: rtl/neopixel_frame_sched_if.sv
// Host-write / writepixel handshake bundle for neopixel_frame_sched.
// Carries i_brightness when NEOPIXEL_SCHED_BRIGHTNESS_EN is defined.
interface neopixel_frame_sched_if #(
    parameter int IDX_W = 4
);
    logic             i_wr_en;
    logic [7:0]       i_wr_data;
    logic             i_wr_sof;
    logic             i_refresh_now;
    logic             i_busy;
`ifdef NEOPIXEL_SCHED_BRIGHTNESS_EN
    logic [7:0]       i_brightness;
`endif
    logic             o_valid;
    logic [7:0]       o_r;
    logic [7:0]       o_g;
    logic [7:0]       o_b;
    logic             o_frame_busy;
    logic             o_frame_done;
    logic [IDX_W-1:0] o_pixel_idx;

`ifdef NEOPIXEL_SCHED_BRIGHTNESS_EN
    modport master (
        output i_wr_en, i_wr_data, i_wr_sof, i_refresh_now, i_busy,
        output i_brightness,
        input  o_valid, o_r, o_g, o_b, o_frame_busy, o_frame_done,
        input  o_pixel_idx
    );
    modport slave (
        input  i_wr_en, i_wr_data, i_wr_sof, i_refresh_now, i_busy,
        input  i_brightness,
        output o_valid, o_r, o_g, o_b, o_frame_busy, o_frame_done,
        output o_pixel_idx
    );
`else
    modport master (
        output i_wr_en, i_wr_data, i_wr_sof, i_refresh_now, i_busy,
        input  o_valid, o_r, o_g, o_b, o_frame_busy, o_frame_done,
        input  o_pixel_idx
    );
    modport slave (
        input  i_wr_en, i_wr_data, i_wr_sof, i_refresh_now, i_busy,
        output o_valid, o_r, o_g, o_b, o_frame_busy, o_frame_done,
        output o_pixel_idx
    );
`endif
endinterface

// File: rtl/neopixel_frame_sched.sv
// Pixel buffer + frame scheduler feeding writepixel one pixel at a time.
// Optional brightness scaling: define NEOPIXEL_SCHED_BRIGHTNESS_EN.
module neopixel_frame_sched #(
    parameter int NUM_PIXELS     = 10,
    parameter int IDX_W          = 4,
    parameter int CNT_W          = 24,
    parameter int REFRESH_CYCLES = 1200000,
    parameter int LATCH_CYCLES   = 1000
) (
    input  logic                  CLK,
    input  logic                  RST,
    neopixel_frame_sched_if.slave bus
);

    localparam int AW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PIXELS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
`ifdef NEOPIXEL_SCHED_BRIGHTNESS_EN
        MUL,
`endif
        SEND,
        WAIT_ACK,
        WAIT_DONE,
        LATCH
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             pend_q, pend_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       r_q, r_d;
    logic [7:0]       g_q, g_d;
    logic [7:0]       b_q, b_d;
    logic [IDX_W-1:0] wr_pix_q, wr_pix_d;
    logic [1:0]       wr_col_q, wr_col_d;
    logic [IDX_W-1:0] tgt_pix;
    logic [1:0]       tgt_col;
    logic             expired;
    logic             done;
    logic [23:0]      rd_pix;

    // No reset on the buffer: contents survive RST, power up as zero.
    logic [23:0] pix_mem_q [NUM_PIXELS] = '{default: 24'h0};

`ifdef NEOPIXEL_SCHED_BRIGHTNESS_EN
    logic [7:0] bri_q, bri_d;

    function automatic logic [7:0] scale(input logic [7:0] c,
                                         input logic [7:0] k);
        logic [15:0] p;
        p = {8'd0, c} * ({8'd0, k} + 16'd1);
        return p[15:8];
    endfunction
`endif

    // sof overrides the pointer for this byte only.
    always_comb begin
        tgt_pix  = bus.i_wr_sof ? '0 : wr_pix_q;
        tgt_col  = bus.i_wr_sof ? 2'd0 : wr_col_q;
        wr_pix_d = wr_pix_q;
        wr_col_d = wr_col_q;
        if (bus.i_wr_en) begin
            if (tgt_col == 2'd2) begin
                wr_col_d = 2'd0;
                wr_pix_d = (tgt_pix == IDX_LAST) ? '0 : tgt_pix + 1'b1;
            end else begin
                wr_col_d = tgt_col + 2'd1;
                wr_pix_d = tgt_pix;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (bus.i_wr_en) begin
            case (tgt_col)
                2'd0:    pix_mem_q[AW'(tgt_pix)][23:16] <= bus.i_wr_data;
                2'd1:    pix_mem_q[AW'(tgt_pix)][15:8]  <= bus.i_wr_data;
                default: pix_mem_q[AW'(tgt_pix)][7:0]   <= bus.i_wr_data;
            endcase
        end
    end

    assign rd_pix  = pix_mem_q[AW'(idx_q)];
    assign expired = (timer_q == REF_LAST);
    assign done    = (state_q == LATCH) && (timer_q == LAT_LAST);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        pend_d  = pend_q | bus.i_refresh_now;
`ifdef NEOPIXEL_SCHED_BRIGHTNESS_EN
        bri_d   = bri_q;
`endif
        unique case (state_q)
            IDLE: begin
                // Saturate so an expiry while busy is not lost.
                if (!expired) timer_d = timer_q + 1'b1;
                if ((expired || pend_d) && !bus.i_busy) begin
                    state_d = LOAD;
                    timer_d = '0;
                    pend_d  = 1'b0;
                    idx_d   = '0;
`ifdef NEOPIXEL_SCHED_BRIGHTNESS_EN
                    bri_d   = bus.i_brightness;
`endif
                end
            end
            LOAD: begin
                r_d = rd_pix[23:16];
                g_d = rd_pix[15:8];
                b_d = rd_pix[7:0];
`ifdef NEOPIXEL_SCHED_BRIGHTNESS_EN
                state_d = MUL;
            end
            MUL: begin
                r_d = scale(r_q, bri_q);
                g_d = scale(g_q, bri_q);
                b_d = scale(b_q, bri_q);
`endif
                state_d = SEND;
            end
            SEND: state_d = WAIT_ACK;
            WAIT_ACK: begin
                if (bus.i_busy) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!bus.i_busy) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = LATCH;
                        timer_d = '0;
                    end else begin
                        state_d = LOAD;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            LATCH: begin
                if (done) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            pend_q   <= 1'b0;
            idx_q    <= '0;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
            wr_pix_q <= '0;
            wr_col_q <= '0;
`ifdef NEOPIXEL_SCHED_BRIGHTNESS_EN
            bri_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            pend_q   <= pend_d;
            idx_q    <= idx_d;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
            wr_pix_q <= wr_pix_d;
            wr_col_q <= wr_col_d;
`ifdef NEOPIXEL_SCHED_BRIGHTNESS_EN
            bri_q    <= bri_d;
`endif
        end
    end

    assign bus.o_valid      = (state_q == SEND);
    assign bus.o_r          = r_q;
    assign bus.o_g          = g_q;
    assign bus.o_b          = b_q;
    assign bus.o_frame_done = done;
    assign bus.o_frame_busy = (state_q != IDLE) && !done;
    assign bus.o_pixel_idx  = idx_q;

endmodule

// File: tb/tb_neopixel_frame_sched.sv
// Directed bench for neopixel_frame_sched with a 10-cycle writepixel model.
// Brightness scenario runs when NEOPIXEL_SCHED_BRIGHTNESS_EN is defined.
module tb_neopixel_frame_sched;

    localparam int NP   = 3;
    localparam int REF  = 200;
    localparam int LAT  = 20;
    localparam int BUSY = 10;
`ifdef NEOPIXEL_SCHED_BRIGHTNESS_EN
    localparam int LD = 2;
`else
    localparam int LD = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    neopixel_frame_sched_if #(.IDX_W(4)) bus ();

    neopixel_frame_sched #(
        .NUM_PIXELS(NP),
        .IDX_W(4),
        .CNT_W(24),
        .REFRESH_CYCLES(REF),
        .LATCH_CYCLES(LAT)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rel     = 0;

    logic busy_m     = 1'b0;
    logic busy_force = 1'b0;
    logic busy_prev  = 1'b0;
    int   bcnt       = 0;

    assign bus.i_busy = busy_m | busy_force;

    always @(posedge clk) cyc <= cyc + 1;

    // writepixel model: busy for BUSY cycles after each accepted strobe
    always @(posedge clk) begin
        if (bcnt != 0) begin
            bcnt <= bcnt - 1;
            if (bcnt == 1) busy_m <= 1'b0;
        end else if (bus.o_valid) begin
            busy_m <= 1'b1;
            bcnt   <= BUSY;
        end
    end

    int          vq_cyc[$];
    logic [23:0] vq_rgb[$];
    int          vq_idx[$];
    int          dq_cyc[$];
    int          bf_cyc[$];

    always @(negedge clk) begin
        if (bus.o_valid) begin
            vq_cyc.push_back(cyc);
            vq_rgb.push_back({bus.o_r, bus.o_g, bus.o_b});
            vq_idx.push_back(int'(bus.o_pixel_idx));
        end
        if (bus.o_frame_done) dq_cyc.push_back(cyc);
        if (busy_prev && !busy_m) bf_cyc.push_back(cyc);
        busy_prev = busy_m;
    end

    task automatic clear_logs();
        vq_cyc.delete();
        vq_rgb.delete();
        vq_idx.delete();
        dq_cyc.delete();
        bf_cyc.delete();
    endtask

    task automatic wait_frames(input int nv, input int nd, input int bound);
        for (int k = 0; k < bound; k++) begin
            if (vq_cyc.size() >= nv && dq_cyc.size() >= nd) break;
            @(negedge clk);
        end
    endtask

    task automatic wr_byte(input logic [7:0] d, input logic sof);
        bus.i_wr_en   = 1'b1;
        bus.i_wr_data = d;
        bus.i_wr_sof  = sof;
        @(negedge clk);
        bus.i_wr_en   = 1'b0;
        bus.i_wr_sof  = 1'b0;
    endtask

    task automatic pulse_refresh();
        bus.i_refresh_now = 1'b1;
        @(negedge clk);
        bus.i_refresh_now = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        rel = cyc;
        clear_logs();
        @(negedge clk);
        n_tests++;
        if ({bus.o_valid, bus.o_frame_busy, bus.o_frame_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 000",
                     {bus.o_valid, bus.o_frame_busy, bus.o_frame_done});
        end
        n_tests++;
        if ({bus.o_r, bus.o_g, bus.o_b, bus.o_pixel_idx} !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_data got %h want 0",
                     {bus.o_r, bus.o_g, bus.o_b, bus.o_pixel_idx});
        end
    endtask

    task automatic test_auto_frame();
        wait_frames(NP, 1, 600);
        n_tests++;
        if (vq_cyc.size() < NP || dq_cyc.size() < 1) begin
            n_fail++;
            $display("FAIL auto_timeout got %0d valids want %0d", vq_cyc.size(), NP);
            return;
        end
        n_tests++;
        if (vq_cyc[0] - rel + 1 !== REF + 1 + LD) begin
            n_fail++;
            $display("FAIL first_valid got %0d want %0d", vq_cyc[0] - rel + 1, REF + 1 + LD);
        end
        for (int i = 1; i < NP; i++) begin
            n_tests++;
            if (vq_cyc[i] - vq_cyc[i-1] !== BUSY + 2 + LD) begin
                n_fail++;
                $display("FAIL valid_gap%0d got %0d want %0d", i,
                         vq_cyc[i] - vq_cyc[i-1], BUSY + 2 + LD);
            end
        end
        for (int i = 0; i < NP; i++) begin
            n_tests++;
            if (vq_idx[i] !== i || vq_rgb[i] !== 24'h0) begin
                n_fail++;
                $display("FAIL pixel%0d_init got idx %0d rgb %h want idx %0d rgb 0",
                         i, vq_idx[i], vq_rgb[i], i);
            end
        end
        n_tests++;
        if (dq_cyc[0] - bf_cyc[bf_cyc.size()-1] !== LAT) begin
            n_fail++;
            $display("FAIL latch_gap got %0d want %0d",
                     dq_cyc[0] - bf_cyc[bf_cyc.size()-1], LAT);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (dq_cyc.size() !== 1 || bus.o_frame_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse got %0d pulses busy %b want 1 pulse busy 0",
                     dq_cyc.size(), bus.o_frame_busy);
        end
    endtask

    task automatic test_write_refresh();
        int p;
        clear_logs();
        wr_byte(8'h11, 1'b1);
        wr_byte(8'h22, 1'b0);
        wr_byte(8'h33, 1'b0);
        wr_byte(8'h44, 1'b0);
        wr_byte(8'h55, 1'b0);
        wr_byte(8'h66, 1'b0);
        p = cyc;
        pulse_refresh();
        n_tests++;
        if (bus.o_frame_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_start got %b want 1", bus.o_frame_busy);
        end
        wait_frames(NP, 1, 300);
        n_tests++;
        if (vq_cyc.size() < NP || dq_cyc.size() < 1) begin
            n_fail++;
            $display("FAIL write_timeout got %0d valids want %0d", vq_cyc.size(), NP);
            return;
        end
        n_tests++;
        if (vq_cyc[0] - p !== 1 + LD) begin
            n_fail++;
            $display("FAIL refresh_latency got %0d want %0d", vq_cyc[0] - p, 1 + LD);
        end
        n_tests++;
        if (vq_rgb[0] !== 24'h112233 || vq_rgb[1] !== 24'h445566 || vq_rgb[2] !== 24'h0) begin
            n_fail++;
            $display("FAIL write_data got %h %h %h want 112233 445566 000000",
                     vq_rgb[0], vq_rgb[1], vq_rgb[2]);
        end
    endtask

    task automatic test_pending();
        clear_logs();
        pulse_refresh();
        wait_frames(1, 0, 50);
        pulse_refresh();
        repeat (5) @(negedge clk);
        pulse_refresh();
        wait_frames(NP, 0, 100);
        pulse_refresh();
        wait_frames(2 * NP + 1, 2, 900);
        n_tests++;
        if (vq_cyc.size() < 2 * NP + 1 || dq_cyc.size() < 2) begin
            n_fail++;
            $display("FAIL pending_timeout got %0d valids want %0d",
                     vq_cyc.size(), 2 * NP + 1);
            return;
        end
        n_tests++;
        if (vq_cyc[NP] - dq_cyc[0] !== 2 + LD) begin
            n_fail++;
            $display("FAIL pending_start got %0d want %0d", vq_cyc[NP] - dq_cyc[0], 2 + LD);
        end
        n_tests++;
        if (vq_cyc[2*NP] - dq_cyc[1] !== REF + 1 + LD) begin
            n_fail++;
            $display("FAIL auto_resume got %0d want %0d",
                     vq_cyc[2*NP] - dq_cyc[1], REF + 1 + LD);
        end
        wait_frames(3 * NP, 3, 300);
    endtask

    task automatic test_write_during();
        clear_logs();
        pulse_refresh();
        wait_frames(1, 0, 50);
        wr_byte(8'hAA, 1'b0);
        wr_byte(8'hBB, 1'b0);
        wr_byte(8'hCC, 1'b0);
        wr_byte(8'h99, 1'b1);
        n_tests++;
        if ({bus.o_r, bus.o_g, bus.o_b} !== 24'h112233) begin
            n_fail++;
            $display("FAIL loaded_hold got %h want 112233", {bus.o_r, bus.o_g, bus.o_b});
        end
        wait_frames(NP, 1, 300);
        n_tests++;
        if (vq_cyc.size() < NP || dq_cyc.size() < 1) begin
            n_fail++;
            $display("FAIL during_timeout got %0d valids want %0d", vq_cyc.size(), NP);
            return;
        end
        n_tests++;
        if (vq_rgb[0] !== 24'h112233 || vq_rgb[1] !== 24'h445566 || vq_rgb[2] !== 24'hAABBCC) begin
            n_fail++;
            $display("FAIL during_data got %h %h %h want 112233 445566 aabbcc",
                     vq_rgb[0], vq_rgb[1], vq_rgb[2]);
        end
    endtask

    task automatic test_reset_mid();
        int s1;
        int bad;
        clear_logs();
        pulse_refresh();
        wait_frames(2, 0, 100);
        n_tests++;
        if (vq_cyc.size() < 2) begin
            n_fail++;
            $display("FAIL mid_timeout got %0d valids want 2", vq_cyc.size());
            return;
        end
        s1 = vq_cyc[1];
        for (int k = 0; k < 20 && cyc < s1 + 4; k++) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        rel = cyc;
        clear_logs();
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.o_valid !== 1'b0 || bus.o_frame_busy !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_quiet got %0d active cycles want 0", bad);
        end
        wait_frames(1, 0, 400);
        n_tests++;
        if (vq_cyc.size() < 1) begin
            n_fail++;
            $display("FAIL post_reset_timeout got 0 valids want 1");
            return;
        end
        n_tests++;
        if (vq_cyc[0] - rel + 1 !== REF + 1 + LD) begin
            n_fail++;
            $display("FAIL post_reset_valid got %0d want %0d",
                     vq_cyc[0] - rel + 1, REF + 1 + LD);
        end
        wait_frames(NP, 1, 300);
    endtask

    task automatic test_busy_gate();
        int bad;
        clear_logs();
        busy_force = 1'b1;
        pulse_refresh();
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.o_valid !== 1'b0 || bus.o_frame_busy !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL busy_gate got %0d active cycles want 0", bad);
        end
        busy_force = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.o_frame_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL gate_release got %b want 1", bus.o_frame_busy);
        end
        wait_frames(NP, 1, 300);
    endtask

`ifdef NEOPIXEL_SCHED_BRIGHTNESS_EN
    task automatic test_brightness();
        clear_logs();
        bus.i_brightness = 8'd127;
        wr_byte(8'hFF, 1'b1);
        wr_byte(8'h80, 1'b0);
        wr_byte(8'h01, 1'b0);
        pulse_refresh();
        wait_frames(1, 0, 50);
        n_tests++;
        if (vq_rgb.size() < 1 || vq_rgb[0] !== 24'h7F4000) begin
            n_fail++;
            $display("FAIL brightness got %h want 7f4000",
                     (vq_rgb.size() > 0) ? vq_rgb[0] : 24'hx);
        end
        bus.i_brightness = 8'd255;
        wait_frames(NP, 1, 300);
    endtask
`endif

    initial begin
        bus.i_wr_en       = 1'b0;
        bus.i_wr_data     = 8'h00;
        bus.i_wr_sof      = 1'b0;
        bus.i_refresh_now = 1'b0;
`ifdef NEOPIXEL_SCHED_BRIGHTNESS_EN
        bus.i_brightness  = 8'd255;
`endif
        test_reset();
        test_auto_frame();
        test_write_refresh();
        test_pending();
        test_write_during();
        test_reset_mid();
        test_busy_gate();
`ifdef NEOPIXEL_SCHED_BRIGHTNESS_EN
        test_brightness();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
